axi4_rd_subordinate: RTL and testbench

- AXI4 read-channel responder (subordinate).
- Accepts AR requests from an AXI4 read host and fetches one word per beat from a synchronous memory port with 1-cycle read latency.
- Returns R beats with ID echo, RLAST and per-beat RESP.
- Sits in front of on-chip BRAM/register banks as the target of the team's AXI read hosts.

---
 rtl/axi4_rd_subordinate.sv | 185 ++++++++++++++++++
 tb/tb_axi4_rd_subordinate.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_subordinate.sv
// AXI4 read-channel subordinate in front of a 1-cycle-latency synchronous memory.
// Issues one memory read per beat and returns R beats through a 2-entry skid buffer.
module axi4_rd_subordinate #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] MEM_BASE  = {ADDR_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_W-1:0]              s_axi_arid,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_W-1:0]              s_axi_rid,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic                         mem_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [DATA_W-1:0]            mem_rdata
);
  localparam int BPW = DATA_W / 8;
  localparam int BSH = $clog2(BPW);
  localparam int MAW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] LIMIT = {1'b0, MEM_BASE} + (ADDR_W+1)'(MEM_DEPTH * BPW);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CHECK = 2'd1, ST_BURST = 2'd2} state_t;

  state_t              r_state;
  logic                r_arready;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic                r_illegal;
  logic [7:0]          r_beat;
  logic                r_iss_done;
  logic                r_fl_valid;
  logic                r_fl_mem;
  logic                r_fl_last;
  logic [DATA_W-1:0]   r_buf_data [2];
  logic [1:0]          r_buf_resp [2];
  logic                r_buf_last [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_count;

  logic [ADDR_W-1:0]   w_step;
  logic [ADDR_W-1:0]   w_wmask;
  logic [ADDR_W-1:0]   w_next;
  logic                w_len_ok;
  logic                w_illegal;
  logic                w_pop;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic                w_in_range;
  logic                w_mem_rd;
  logic                w_is_last;

  assign w_step   = ADDR_W'(1) << r_size;
  assign w_wmask  = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);
  assign w_len_ok = (r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15);
  assign w_illegal = (r_size > 3'(BSH)) || (r_burst == 2'd3) ||
                     ((r_burst == 2'd2) && (!w_len_ok || ((r_addr & (w_step - ADDR_W'(1))) != {ADDR_W{1'b0}})));

  // Credit check: buffered + in-flight - popped must leave room for one more beat.
  assign w_pop      = (r_count != 2'd0) && s_axi_rready;
  assign w_occ      = {1'b0, r_count} + {2'b00, r_fl_valid} - {2'b00, w_pop};
  assign w_issue    = (r_state == ST_BURST) && !r_iss_done && (w_occ < 3'd2);
  assign w_is_last  = (r_beat == r_len);
  assign w_in_range = ({1'b0, r_addr} >= {1'b0, MEM_BASE}) && ({1'b0, r_addr} < LIMIT);
  assign w_mem_rd   = w_issue && !r_illegal && w_in_range;

  assign mem_en        = w_mem_rd;
  assign mem_addr      = w_mem_rd ? MAW'((r_addr - MEM_BASE) >> BSH) : {MAW{1'b0}};
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = (r_count != 2'd0);
  assign s_axi_rid     = r_id;
  assign s_axi_rdata   = r_buf_data[r_rptr];
  assign s_axi_rresp   = r_buf_resp[r_rptr];
  assign s_axi_rlast   = r_buf_last[r_rptr];

  // Next beat address for FIXED / INCR / WRAP bursts.
  always_comb begin
    w_next = r_addr;
    case (r_burst)
      2'd0:    w_next = r_addr;
      2'd1:    w_next = r_addr + w_step;
      2'd2:    w_next = (r_addr & ~w_wmask) | ((r_addr + w_step) & w_wmask);
      default: w_next = r_addr;
    endcase
  end

  // Control FSM, beat issue pipeline and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_arready     <= 1'b0;
      r_id          <= {ID_W{1'b0}};
      r_addr        <= {ADDR_W{1'b0}};
      r_len         <= 8'd0;
      r_size        <= 3'd0;
      r_burst       <= 2'd0;
      r_illegal     <= 1'b0;
      r_beat        <= 8'd0;
      r_iss_done    <= 1'b0;
      r_fl_valid    <= 1'b0;
      r_fl_mem      <= 1'b0;
      r_fl_last     <= 1'b0;
      r_buf_data[0] <= {DATA_W{1'b0}};
      r_buf_data[1] <= {DATA_W{1'b0}};
      r_buf_resp[0] <= 2'd0;
      r_buf_resp[1] <= 2'd0;
      r_buf_last[0] <= 1'b0;
      r_buf_last[1] <= 1'b0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_axi_arvalid && r_arready) begin
            r_id       <= s_axi_arid;
            r_addr     <= s_axi_araddr;
            r_len      <= s_axi_arlen;
            r_size     <= s_axi_arsize;
            r_burst    <= s_axi_arburst;
            r_beat     <= 8'd0;
            r_iss_done <= 1'b0;
            r_arready  <= 1'b0;
            r_state    <= ST_CHECK;
          end else begin
            r_arready  <= 1'b1;
          end
        end
        ST_CHECK: begin
          r_illegal <= w_illegal;
          r_state   <= ST_BURST;
        end
        ST_BURST: begin
          if (w_issue) begin
            if (w_is_last) begin
              r_iss_done <= 1'b1;
            end else begin
              r_beat <= r_beat + 8'd1;
              r_addr <= w_next;
            end
          end
          if (w_pop && r_buf_last[r_rptr]) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arready <= 1'b0;
        end
      endcase

      r_fl_valid <= w_issue;
      r_fl_mem   <= w_mem_rd;
      r_fl_last  <= w_issue && w_is_last;

      // mem_rdata is valid the cycle after mem_en; refused beats carry zero data.
      if (r_fl_valid) begin
        r_buf_data[r_wptr] <= r_fl_mem ? mem_rdata : {DATA_W{1'b0}};
        r_buf_resp[r_wptr] <= r_fl_mem ? 2'd0 : 2'd2;
        r_buf_last[r_wptr] <= r_fl_last;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, r_fl_valid} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_axi4_rd_subordinate.sv
// Self-checking bench for axi4_rd_subordinate: directed plan bursts plus random bursts
// and random backpressure, checked every cycle against a queue-based beat model.
`timescale 1ns/1ps
module tb_axi4_rd_subordinate;
  localparam int DATA_W = 32, ADDR_W = 32, ID_W = 4, MEM_DEPTH = 1024, BPW = DATA_W / 8;
  localparam int MAW = $clog2(MEM_DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ID_W-1:0]   arid = '0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [7:0]        arlen = '0;
  logic [2:0]        arsize = '0;
  logic [1:0]        arburst = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid;
  logic              rready = 1'b1;
  logic              mem_en;
  logic [MAW-1:0]    mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  axi4_rd_subordinate #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH),
                        .MEM_BASE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata));

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst_d = 1'b0;
  always @(posedge clk) rst_d <= rst;

  int n_cmp = 0, n_mis = 0;
  logic [DATA_W-1:0] q_data[$];
  logic [1:0]        q_resp[$];
  bit                q_last[$];
  int                pop_cyc[$];
  logic [ID_W-1:0]   exp_id = '0;
  int exp_mem = 0, memcnt = 0, first_rv = -1, first_mem = -1, hs_cyc = 0, pops = 0;
  bit busy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected beats from the burst rules, appended to the model queues.
  task automatic model(input logic [31:0] addr, input int len, input int size, input int burst);
    logic [31:0] a, sz, cont, lo;
    bit ill;
    sz  = 32'd1 << size;
    ill = (sz > 32'(BPW)) || (burst == 3) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
          (burst == 2 && (addr % sz) != 32'd0);
    a = addr;
    exp_mem = 0;
    for (int b = 0; b <= len; b++) begin
      if (!ill && a < 32'(MEM_DEPTH * BPW)) begin
        q_data.push_back(mem[a / 32'(BPW)]);
        q_resp.push_back(2'd0);
        exp_mem++;
      end else begin
        q_data.push_back('0);
        q_resp.push_back(2'd2);
      end
      q_last.push_back(b == len);
      if (burst == 1) a = a + sz;
      else if (burst == 2) begin
        cont = 32'(len + 1) * sz;
        lo   = a - (a % cont);
        a    = lo + ((a + sz - lo) % cont);
      end
    end
  endtask

  task automatic clear_model();
    q_data.delete(); q_resp.delete(); q_last.delete();
  endtask

  task automatic drive_ar(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst);
    bit ok = 0;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    exp_id = id; first_rv = -1; first_mem = -1; memcnt = 0; pop_cyc.delete();
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (arready) begin @(posedge clk); #1; ok = 1; end
    end
    arvalid = 1'b0;
    if (!ok) begin
      chk("ar_handshake_timeout", 64'd0, 64'd1);
      clear_model();
    end else begin
      hs_cyc = cyc; busy = 1;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && busy; i++) begin @(posedge clk); #1; end
    if (busy) begin
      chk("burst_timeout", 64'd0, 64'd1);
      busy = 0; clear_model();
    end
  endtask

  // rready driver: explicit pattern first, else always-high or random.
  int rr_mode = 0;
  bit rr_pat[$];
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_pat.size() > 0) rready = rr_pat.pop_front();
      else if (rr_mode == 1) rready = ($urandom_range(0, 3) != 0);
      else rready = 1'b1;
    end
  end

  // Per-cycle compare process, sampled on the falling edge.
  bit held = 0;
  logic [DATA_W-1:0] h_data; logic [1:0] h_resp; logic h_last; logic [ID_W-1:0] h_id;
  always @(negedge clk) begin
    if (rst_d) begin
      chk("reset_outs", {arready, rvalid, rlast, rresp, rid, rdata, mem_en, mem_addr}, 64'd0);
      held = 0; memcnt = 0;
    end else if (!rst) begin
      chk("arready", arready, !busy);
      if (mem_en) begin memcnt++; if (first_mem < 0) first_mem = cyc; end
      if (held) begin
        chk("hold_rvalid", rvalid, 64'd1);
        if (rvalid) chk("hold_stable", {rdata, rresp, rlast, rid}, {h_data, h_resp, h_last, h_id});
      end
      if (rvalid) begin
        if (first_rv < 0) first_rv = cyc;
        if (q_data.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          chk("rdata", rdata, q_data[0]);
          chk("rresp", rresp, q_resp[0]);
          chk("rlast", rlast, q_last[0]);
          chk("rid", rid, exp_id);
          if (rready) begin
            pops++; pop_cyc.push_back(cyc);
            if (q_last[0]) begin chk("mem_en_count", memcnt, exp_mem); busy = 0; end
            q_data.delete(0); q_resp.delete(0); q_last.delete(0);
          end
        end
      end
      held = rvalid && !rready;
      h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_mis=%0d expected 0", n_mis);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e4[4];
    int base;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: INCR id=5 addr=0x10 len=3 size=2
    model(32'h10, 3, 2, 1);
    e4 = '{32'd4, 32'd5, 32'd6, 32'd7};
    for (int k = 0; k < 4; k++) chk("pin_t1_data", q_data[k], e4[k]);
    chk("pin_t1_last", {q_last[0], q_last[1], q_last[2], q_last[3]}, 64'b0001);
    drive_ar(4'd5, 32'h10, 3, 2, 1);
    wait_done();
    chk("t1_first_rvalid_latency", 64'(first_rv - hs_cyc), 64'd3);
    chk("t1_first_mem_en_latency", 64'(first_mem - hs_cyc), 64'd1);
    chk("t1_back_to_back", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

    // 2: WRAP legal and illegal
    model(32'h18, 3, 2, 2);
    e4 = '{32'd6, 32'd7, 32'd4, 32'd5};
    for (int k = 0; k < 4; k++) chk("pin_t2_wrap_data", q_data[k], e4[k]);
    drive_ar(4'd2, 32'h18, 3, 2, 2); wait_done();
    model(32'h18, 2, 2, 2);
    chk("pin_t2_bad_wrap", {q_resp[0], q_resp[1], q_resp[2], q_data[1]}, {2'd2, 2'd2, 2'd2, 32'd0});
    chk("pin_t2_bad_wrap_mem", exp_mem, 64'd0);
    drive_ar(4'd3, 32'h18, 2, 2, 2); wait_done();

    // 3: FIXED and single beat
    model(32'h8, 2, 2, 0);
    chk("pin_t3_fixed", {q_data[0], q_data[1], q_data[2]}, {32'd2, 32'd2, 32'd2});
    drive_ar(4'd7, 32'h8, 2, 2, 0); wait_done();
    model(32'h20, 0, 2, 1);
    chk("pin_t3_single", {q_data[0], 31'd0, q_last[0]}, {32'd8, 32'd1});
    drive_ar(4'd1, 32'h20, 0, 2, 1); wait_done();

    // 4: INCR len=15 with stalls
    model(32'h0, 15, 2, 1);
    chk("pin_t4_last_data", q_data[15], 64'd15);
    drive_ar(4'd9, 32'h0, 15, 2, 1);
    rr_pat = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    wait_done();

    // 5: window edge and oversize beats
    model(32'hFFC, 1, 2, 1);
    chk("pin_t5_edge", {q_data[0], q_resp[0], q_data[1], q_resp[1]}, {32'd1023, 2'd0, 32'd0, 2'd2});
    drive_ar(4'd4, 32'hFFC, 1, 2, 1); wait_done();
    model(32'h0, 3, 3, 1);
    chk("pin_t5_size3", {q_resp[0], q_resp[3]}, {2'd2, 2'd2});
    drive_ar(4'd6, 32'h0, 3, 3, 1); wait_done();

    // 6: reset mid-burst, then a clean burst
    model(32'h40, 7, 2, 1);
    drive_ar(4'd8, 32'h40, 7, 2, 1);
    base = pops;
    for (int i = 0; i < 100 && pops < base + 2; i++) begin @(posedge clk); #1; end
    chk("t6_beats_before_rst", 64'(pops - base), 64'd2);
    rst = 1'b1; busy = 0; clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model(32'h0, 1, 2, 1);
    chk("pin_t6_after", {q_data[0], q_data[1]}, {32'd0, 32'd1});
    drive_ar(4'd10, 32'h0, 1, 2, 1); wait_done();

    // Random bursts with random backpressure and random memory contents.
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    rr_mode = 1;
    model(32'hF00, 255, 2, 1);
    drive_ar(4'd11, 32'hF00, 255, 2, 1); wait_done();
    for (int n = 0; n < 60; n++) begin
      int sz, bt, ln;
      logic [31:0] ad;
      sz = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0:          bt = 0;
        1, 2, 3, 4: bt = 1;
        5, 6:       bt = 2;
        default:    bt = 3;
      endcase
      if (bt == 2 && $urandom_range(0, 3) != 0) ln = (2 << $urandom_range(0, 3)) - 1;
      else ln = $urandom_range(0, 20);
      ad = $urandom_range(0, 32'h1080);
      if ($urandom_range(0, 1) == 1) ad = ad & ~((32'd1 << sz) - 32'd1);
      model(ad, ln, sz, bt);
      drive_ar(4'($urandom), ad, ln, sz, bt);
      wait_done();
    end
    rr_mode = 0;
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
